// File: rtl/getir1_ps_uretici_if.sv
`default_nettype none
// ============================================================================
// Module  : getir1_ps_uretici_if
// Brief   : L1B request / second-stage PS / pipeline-control bundle.
// Rev     : 1.0
// ============================================================================
interface getir1_ps_uretici_if;
    logic [31:0] l1b_istek_ps_o;
    logic        l1b_istek_gecerli_o;
    logic        l1b_istek_hazir_i;
    logic        g2_istek_yapildi_o;
    logic [31:0] g2_ps_o;
    logic        g2_ps_gecerli_o;
    logic        g2_ps_hazir_i;
    logic [31:0] g2_dallanma_ps_i;
    logic        g2_dallanma_gecerli_i;
    logic [31:0] cek_ps_i;
    logic        cek_bosalt_i;
    logic        cek_duraklat_i;

    modport master (
        output l1b_istek_ps_o, l1b_istek_gecerli_o, g2_istek_yapildi_o,
               g2_ps_o, g2_ps_gecerli_o,
        input  l1b_istek_hazir_i, g2_ps_hazir_i, g2_dallanma_ps_i,
               g2_dallanma_gecerli_i, cek_ps_i, cek_bosalt_i, cek_duraklat_i
    );

    modport slave (
        input  l1b_istek_ps_o, l1b_istek_gecerli_o, g2_istek_yapildi_o,
               g2_ps_o, g2_ps_gecerli_o,
        output l1b_istek_hazir_i, g2_ps_hazir_i, g2_dallanma_ps_i,
               g2_dallanma_gecerli_i, cek_ps_i, cek_bosalt_i, cek_duraklat_i
    );
endinterface
`default_nettype wire

// File: rtl/getir1_ps_uretici.sv
`default_nettype none
// ============================================================================
// Module  : getir1_ps_uretici
// Brief   : First fetch stage: PS owner, L1B request issue, in-order PS FIFO.
//           Define GETIR1_DALLANMA_EN to compile in second-stage redirects.
// Rev     : 1.0
// ============================================================================
module getir1_ps_uretici #(
    parameter logic [31:0] RESET_PS         = 32'h4000_0000,
    parameter int unsigned PS_FIFO_DERINLIK = 4
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_i,
    getir1_ps_uretici_if.master       bus
);
    localparam int unsigned    AW     = $clog2(PS_FIFO_DERINLIK);
    localparam logic [AW:0]    C_DOLU = (AW+1)'(PS_FIFO_DERINLIK);

    logic [31:0]   ps_q, ps_d;
    logic [31:0]   fifo_q [PS_FIFO_DERINLIK];
    logic [31:0]   fifo_d [PS_FIFO_DERINLIK];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   sayi_q, sayi_d;

    logic w_dolu, w_bos, w_istek, w_push, w_pop;

    // Fullness comes from registered count only, so a same-cycle pop never
    // opens a slot and hazir has no path back into gecerli.
    assign w_dolu  = (sayi_q == C_DOLU);
    assign w_bos   = (sayi_q == '0);
    assign w_istek = !rst_i && !w_dolu && !bus.cek_duraklat_i && !bus.cek_bosalt_i;
    assign w_push  = w_istek && bus.l1b_istek_hazir_i;
    assign w_pop   = !w_bos && bus.g2_ps_hazir_i;

    assign bus.l1b_istek_ps_o      = ps_q;
    assign bus.l1b_istek_gecerli_o = w_istek;
    assign bus.g2_istek_yapildi_o  = w_push;
    assign bus.g2_ps_o             = fifo_q[rp_q];
    assign bus.g2_ps_gecerli_o     = !w_bos;

`ifndef GETIR1_DALLANMA_EN
    logic w_unused_dallanma;
    assign w_unused_dallanma = ^{bus.g2_dallanma_ps_i, bus.g2_dallanma_gecerli_i};
`endif

    always_comb begin
        ps_d   = ps_q;
        fifo_d = fifo_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        sayi_d = sayi_q;
        if (bus.cek_bosalt_i) begin
            ps_d   = bus.cek_ps_i;
            wp_d   = '0;
            rp_d   = '0;
            sayi_d = '0;
        end else begin
            if (w_push) begin
                fifo_d[wp_q] = ps_q;
                wp_d         = wp_q + AW'(1);
                ps_d         = ps_q + 32'd4;
            end
`ifdef GETIR1_DALLANMA_EN
            // Redirect wins over +4; the accepted old PS is still pushed.
            if (bus.g2_dallanma_gecerli_i) begin
                ps_d = bus.g2_dallanma_ps_i;
            end
`endif
            if (w_pop) begin
                rp_d = rp_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   sayi_d = sayi_q + (AW+1)'(1);
                2'b01:   sayi_d = sayi_q - (AW+1)'(1);
                default: sayi_d = sayi_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ps_q   <= RESET_PS;
            wp_q   <= '0;
            rp_q   <= '0;
            sayi_q <= '0;
            for (int i = 0; i < int'(PS_FIFO_DERINLIK); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            ps_q   <= ps_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            sayi_q <= sayi_d;
            fifo_q <= fifo_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_getir1_ps_uretici.sv
`default_nettype none
// ============================================================================
// Module  : tb_getir1_ps_uretici
// Brief   : Self-checking bench for getir1_ps_uretici against a queue model.
// Rev     : 1.0
// ============================================================================
module tb_getir1_ps_uretici;
    localparam logic [31:0] RESET_PS = 32'h4000_0000;
    localparam int          D        = 4;
`ifdef GETIR1_DALLANMA_EN
    localparam bit DAL_EN = 1'b1;
`else
    localparam bit DAL_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    getir1_ps_uretici_if bus();

    getir1_ps_uretici #(.RESET_PS(RESET_PS), .PS_FIFO_DERINLIK(D)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_ps;
    logic [31:0] m_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    // One clock of stimulus: drive, check outputs against the model, advance model.
    task automatic step(input bit hz, input bit g2hz, input bit fl, input logic [31:0] cps,
                        input bit st, input bit dal, input logic [31:0] dps);
        bit exp_gec, acc, pop;
        bus.l1b_istek_hazir_i     = hz;
        bus.g2_ps_hazir_i         = g2hz;
        bus.cek_bosalt_i          = fl;
        bus.cek_ps_i              = cps;
        bus.cek_duraklat_i        = st;
        bus.g2_dallanma_gecerli_i = dal;
        bus.g2_dallanma_ps_i      = dps;
        #3;
        exp_gec = (m_q.size() < D) && !st && !fl;
        chk("istek_gecerli", {31'd0, bus.l1b_istek_gecerli_o}, {31'd0, exp_gec});
        chk("istek_ps", bus.l1b_istek_ps_o, m_ps);
        chk("yapildi", {31'd0, bus.g2_istek_yapildi_o}, {31'd0, exp_gec && hz});
        chk("g2_gecerli", {31'd0, bus.g2_ps_gecerli_o}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0) chk("g2_ps", bus.g2_ps_o, m_q[0]);
        acc = exp_gec && hz;
        pop = (m_q.size() != 0) && g2hz;
        if (fl) begin
            m_q.delete();
            m_ps = cps;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(m_ps);
            if (dal && DAL_EN) m_ps = dps;
            else if (acc)      m_ps = m_ps + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit hz, input bit g2hz);
        step(hz, g2hz, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.l1b_istek_hazir_i     = 1'b1;
        bus.g2_ps_hazir_i         = 1'b0;
        bus.g2_dallanma_ps_i      = '0;
        bus.g2_dallanma_gecerli_i = 1'b0;
        bus.cek_ps_i              = '0;
        bus.cek_bosalt_i          = 1'b0;
        bus.cek_duraklat_i        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gecerli", {31'd0, bus.l1b_istek_gecerli_o}, 32'd0);
        chk("rst_yapildi", {31'd0, bus.g2_istek_yapildi_o}, 32'd0);
        chk("rst_g2_gecerli", {31'd0, bus.g2_ps_gecerli_o}, 32'd0);
        chk("rst_g2_ps", bus.g2_ps_o, 32'd0);
        chk("rst_ps", bus.l1b_istek_ps_o, RESET_PS);
        rst  = 1'b0;
        m_ps = RESET_PS;
        m_q.delete();

        // Fill to full, one more cycle blocked, pop frees a slot a cycle later.
        repeat (4) idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        chk("full_next_ps", bus.l1b_istek_ps_o, 32'h4000_0010);
        idle(1'b1, 1'b0);

        // Down to two entries, then simultaneous pop and accept.
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);
        chk("pushpop_head", bus.g2_ps_o, 32'h4000_0010);

        // Flush with three pending and hazir high.
        idle(1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 1'b0, 32'd0);
        chk("flush_empty", {31'd0, bus.g2_ps_gecerli_o}, 32'd0);
        chk("flush_ps", bus.l1b_istek_ps_o, 32'h8000_0100);

        // Redirect on the same cycle 4000_0008 is accepted.
        step(1'b0, 1'b0, 1'b1, 32'h4000_0000, 1'b0, 1'b0, 32'd0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h4000_1000);
        chk("redirect_ps", bus.l1b_istek_ps_o, DAL_EN ? 32'h4000_1000 : 32'h4000_000C);

        // Stall three cycles with pops draining.
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("stall_drained", {31'd0, bus.g2_ps_gecerli_o}, 32'd0);

        // Address wrap.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0);
        idle(1'b1, 1'b0);
        chk("wrap_ps", bus.l1b_istek_ps_o, 32'h0000_0000);
        idle(1'b0, 1'b1);
        chk("wrap_head", bus.g2_ps_gecerli_o ? 32'd1 : 32'd0, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit fl;
            logic [31:0] cps;
            fl  = ($urandom % 20) == 0;
            cps = (($urandom % 4) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            step(($urandom % 4) != 0, ($urandom % 3) == 0, fl, cps,
                 ($urandom % 6) == 0, ($urandom % 10) == 0, $urandom & 32'hFFFF_FFFC);
        end

        // Asynchronous reset between edges.
        idle(1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_gecerli", {31'd0, bus.l1b_istek_gecerli_o}, 32'd0);
        chk("arst_g2_gecerli", {31'd0, bus.g2_ps_gecerli_o}, 32'd0);
        chk("arst_g2_ps", bus.g2_ps_o, 32'd0);
        chk("arst_ps", bus.l1b_istek_ps_o, RESET_PS);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        m_ps = RESET_PS;
        m_q.delete();
        repeat (6) idle(1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
